// File: rtl/pcs_sync_multi_pkg.sv
// Shared definitions for the multi-lane 1000BASE-X code-group synchronization block.
package pcs_sync_multi_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] SYNC_LOSS = 2'd0;
  localparam logic [STATE_W-1:0] SYNC_CDET = 2'd1;
  localparam logic [STATE_W-1:0] SYNC_ACQ  = 2'd2;
  localparam logic [STATE_W-1:0] SYNC_OK   = 2'd3;

  localparam int unsigned DEF_LANES       = 1;
  localparam int unsigned DEF_ACQ_COMMAS  = 3;
  localparam int unsigned DEF_LOSS_THRESH = 4;
  localparam int unsigned DEF_GOOD_RUN    = 4;
  localparam int unsigned DEF_CNT_W       = 8;

  localparam int unsigned ACQ_W  = 3;
  localparam int unsigned BAD_W  = 3;
  localparam int unsigned GOOD_W = 4;

endpackage

// File: rtl/pcs_sync_lane.sv
// One lane of code-group synchronization: FSM, acquisition/bad-level counters
// and a saturating loss-of-sync event counter.
module pcs_sync_lane
  import pcs_sync_multi_pkg::*;
#(
  parameter int unsigned ACQ_COMMAS  = DEF_ACQ_COMMAS,
  parameter int unsigned LOSS_THRESH = DEF_LOSS_THRESH,
  parameter int unsigned GOOD_RUN    = DEF_GOOD_RUN,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cg_en,
  input  logic             cg_comma,
  input  logic             cg_invalid,
  input  logic             signal_detect,
  input  logic             cnt_clear,
  output logic             sync_status,
  output logic             rx_even,
  output logic [CNT_W-1:0] loss_cnt
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               sync_q, sync_d;
  logic               rx_even_q, rx_even_d;
  logic [ACQ_W-1:0]   acq_cnt_q, acq_cnt_d;
  logic [BAD_W-1:0]   bad_lvl_q, bad_lvl_d;
  logic [GOOD_W-1:0]  good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0]   loss_cnt_q, loss_cnt_d;
  logic               cg_bad;
  logic               loss_inc;

  always_comb begin
    state_d    = state_q;
    rx_even_d  = rx_even_q;
    acq_cnt_d  = acq_cnt_q;
    bad_lvl_d  = bad_lvl_q;
    good_cnt_d = good_cnt_q;
    loss_cnt_d = loss_cnt_q;
    cg_bad     = cg_invalid | (cg_comma & rx_even_q);

    if (!signal_detect) begin
      state_d = SYNC_LOSS;
      if (cg_en) rx_even_d = ~rx_even_q;
    end else if (cg_en) begin
      case (state_q)
        SYNC_LOSS: begin
          rx_even_d = ~rx_even_q;
          if (cg_comma) begin
            state_d   = SYNC_CDET;
            acq_cnt_d = ACQ_W'(1);
            rx_even_d = 1'b1;
          end
        end
        SYNC_CDET: begin
          if (cg_invalid) begin
            state_d   = SYNC_LOSS;
            rx_even_d = ~rx_even_q;
          end else begin
            state_d   = SYNC_ACQ;
            rx_even_d = 1'b0;
          end
        end
        SYNC_ACQ: begin
          rx_even_d = ~rx_even_q;
          if (cg_bad) begin
            state_d = SYNC_LOSS;
          end else if (cg_comma) begin
            rx_even_d = 1'b1;
            if (acq_cnt_q == ACQ_W'(ACQ_COMMAS - 1)) begin
              state_d = SYNC_OK;
            end else begin
              state_d   = SYNC_CDET;
              acq_cnt_d = acq_cnt_q + ACQ_W'(1);
            end
          end
        end
        default: begin
          rx_even_d = cg_comma ? 1'b1 : ~rx_even_q;
          if (cg_bad) begin
            good_cnt_d = '0;
            if (bad_lvl_q == BAD_W'(LOSS_THRESH - 1)) state_d = SYNC_LOSS;
            else bad_lvl_d = bad_lvl_q + BAD_W'(1);
          end else if (bad_lvl_q != '0) begin
            // A full run of good code-groups earns back one bad-level step
            if (good_cnt_q == GOOD_W'(GOOD_RUN - 1)) begin
              bad_lvl_d  = bad_lvl_q - BAD_W'(1);
              good_cnt_d = '0;
            end else begin
              good_cnt_d = good_cnt_q + GOOD_W'(1);
            end
          end
        end
      endcase
    end

    if (state_d == SYNC_LOSS) begin
      acq_cnt_d  = '0;
      bad_lvl_d  = '0;
      good_cnt_d = '0;
    end

    loss_inc = (state_q == SYNC_OK) && (state_d == SYNC_LOSS);
    if (cnt_clear) loss_cnt_d = '0;
    else if (loss_inc && (loss_cnt_q != {CNT_W{1'b1}})) loss_cnt_d = loss_cnt_q + CNT_W'(1);

    sync_d = (state_d == SYNC_OK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SYNC_LOSS;
      sync_q     <= 1'b0;
      rx_even_q  <= 1'b0;
      acq_cnt_q  <= '0;
      bad_lvl_q  <= '0;
      good_cnt_q <= '0;
      loss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      rx_even_q  <= rx_even_d;
      acq_cnt_q  <= acq_cnt_d;
      bad_lvl_q  <= bad_lvl_d;
      good_cnt_q <= good_cnt_d;
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign sync_status = sync_q;
  assign rx_even     = rx_even_q;
  assign loss_cnt    = loss_cnt_q;

endmodule

// File: rtl/pcs_sync_multi.sv
// Multi-lane 1000BASE-X code-group synchronization: independent per-lane sync
// FSMs plus an aggregate all-lanes-synced flag.
module pcs_sync_multi
  import pcs_sync_multi_pkg::*;
#(
  parameter int unsigned LANES       = DEF_LANES,
  parameter int unsigned ACQ_COMMAS  = DEF_ACQ_COMMAS,
  parameter int unsigned LOSS_THRESH = DEF_LOSS_THRESH,
  parameter int unsigned GOOD_RUN    = DEF_GOOD_RUN,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES-1:0]       cg_en,
  input  logic [LANES-1:0]       cg_comma,
  input  logic [LANES-1:0]       cg_invalid,
  input  logic [LANES-1:0]       signal_detect,
  input  logic                   cnt_clear,
  output logic [LANES-1:0]       sync_status,
  output logic [LANES-1:0]       rx_even,
  output logic                   all_sync,
  output logic [LANES*CNT_W-1:0] loss_cnt
);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    pcs_sync_lane #(
      .ACQ_COMMAS (ACQ_COMMAS),
      .LOSS_THRESH(LOSS_THRESH),
      .GOOD_RUN   (GOOD_RUN),
      .CNT_W      (CNT_W)
    ) u_lane (
      .clk          (clk),
      .reset        (reset),
      .cg_en        (cg_en[g]),
      .cg_comma     (cg_comma[g]),
      .cg_invalid   (cg_invalid[g]),
      .signal_detect(signal_detect[g]),
      .cnt_clear    (cnt_clear),
      .sync_status  (sync_status[g]),
      .rx_even      (rx_even[g]),
      .loss_cnt     (loss_cnt[g*CNT_W +: CNT_W])
    );
  end

  // Derived from registered per-lane status, so no extra flop stage
  assign all_sync = &sync_status;

endmodule

// File: tb/tb_pcs_sync_multi.sv
// Self-checking bench for pcs_sync_multi: two lanes, 2-bit loss counters.
module tb_pcs_sync_multi;

  typedef struct {
    logic [1:0] en, comma, inv, sd;
    logic       clr, rst;
    logic [1:0] e_sync, e_l0, e_l1, e_even, e_echk;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] cg_en = '0, cg_comma = '0, cg_invalid = '0, signal_detect = 2'b11;
  logic       cnt_clear = 1'b0;
  logic [1:0] sync_status, rx_even;
  logic       all_sync;
  logic [3:0] loss_cnt;

  logic [1:0] e_sync = '0, e_l0 = '0, e_l1 = '0, e_even = '0, e_echk = '0;
  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0;
  int   failures = 0;

  pcs_sync_multi #(.LANES(2), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .cg_en(cg_en), .cg_comma(cg_comma),
    .cg_invalid(cg_invalid), .signal_detect(signal_detect), .cnt_clear(cnt_clear),
    .sync_status(sync_status), .rx_even(rx_even), .all_sync(all_sync), .loss_cnt(loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic v(input logic [1:0] en, comma, inv, sd, input logic clr, rst);
    vec_t t;
    t.en = en; t.comma = comma; t.inv = inv; t.sd = sd; t.clr = clr; t.rst = rst;
    t.e_sync = e_sync; t.e_l0 = e_l0; t.e_l1 = e_l1; t.e_even = e_even; t.e_echk = e_echk;
    tbl.push_back(t);
  endtask

  task automatic cg(input int lane, input logic comma, inv, input int gap);
    logic [1:0] m;
    m = 2'(2'b01 << lane);
    v(m, comma ? m : 2'b00, inv ? m : 2'b00, 2'b11, 1'b0, 1'b0);
    for (int k = 0; k < gap; k++) v(2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0);
  endtask

  // comma, data, comma, data, comma: sync one clock after the third comma
  task automatic acq(input int lane, input int gap);
    cg(lane, 1, 0, gap); cg(lane, 0, 0, gap); cg(lane, 1, 0, gap); cg(lane, 0, 0, gap);
    e_sync[lane] = 1'b1;
    cg(lane, 1, 0, gap);
  endtask

  task automatic sdrop(input int lane, input logic clr);
    logic [1:0] m;
    m = 2'(2'b01 << lane);
    v(2'b00, 2'b00, 2'b00, ~m, clr, 1'b0);
  endtask

  task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    vec_t e;

    // reset state
    e_echk = 2'b11; e_even = 2'b00;
    v(2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 1'b1);
    v(2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0);

    // lane 0 acquisition with rx_even tracking; lane 1 stays idle
    e_echk = 2'b01;
    e_even[0] = 1'b1; cg(0, 1, 0, 0);
    e_even[0] = 1'b0; cg(0, 0, 0, 0);
    e_even[0] = 1'b1; cg(0, 1, 0, 0);
    e_even[0] = 1'b0; cg(0, 0, 0, 0);
    e_even[0] = 1'b1; e_sync[0] = 1'b1; cg(0, 1, 0, 0);
    e_echk = 2'b00;

    // invalid, 4 good, invalid, 4 good, invalid, invalid: never reaches threshold
    for (int r = 0; r < 2; r++) begin
      cg(0, 0, 1, 0);
      for (int k = 0; k < 4; k++) cg(0, 0, 0, 0);
    end
    cg(0, 0, 1, 0); cg(0, 0, 1, 0);
    for (int k = 0; k < 8; k++) cg(0, 0, 0, 0);

    // four consecutive invalids lose sync on the fourth
    for (int k = 0; k < 3; k++) cg(0, 0, 1, 0);
    e_sync[0] = 1'b0; e_l0 = 2'd1;
    cg(0, 0, 1, 0);

    // comma at even position during ACQUIRE: back to loss, no counter bump
    cg(0, 1, 0, 0); cg(0, 0, 0, 0); cg(0, 0, 0, 0); cg(0, 1, 0, 0);
    acq(0, 0);

    // signal_detect drop with cg_en low, then counter saturation
    e_sync[0] = 1'b0; e_l0 = 2'd2; sdrop(0, 1'b0);
    v(2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0);
    acq(0, 0); e_sync[0] = 1'b0; e_l0 = 2'd3; sdrop(0, 1'b0);
    acq(0, 0); e_sync[0] = 1'b0; sdrop(0, 1'b0);
    acq(0, 0); e_sync[0] = 1'b0; sdrop(0, 1'b0);

    // clear coincident with a loss event
    acq(0, 0); e_sync[0] = 1'b0; e_l0 = 2'd0; sdrop(0, 1'b1);
    acq(0, 0);

    // lane 1 gapped acquisition and loss while lane 0 holds sync
    acq(1, 2);
    for (int k = 0; k < 3; k++) cg(1, 0, 1, 2);
    e_sync[1] = 1'b0; e_l1 = 2'd1;
    cg(1, 0, 1, 2);

    // reset while lane 1 sits in ACQUIRE
    cg(1, 1, 0, 0); cg(1, 0, 0, 0);
    e_sync = 2'b00; e_l0 = 2'd0; e_l1 = 2'd0; e_echk = 2'b11; e_even = 2'b00;
    v(2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 1'b1);
    v(2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      cg_en = tbl[i].en; cg_comma = tbl[i].comma; cg_invalid = tbl[i].inv;
      signal_detect = tbl[i].sd; cnt_clear = tbl[i].clr; reset = tbl[i].rst;
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty vec=%0d", i);
      end else begin
        e = sb.pop_front();
        chk("sync_status", i, {2'b00, sync_status}, {2'b00, e.e_sync});
        chk("all_sync", i, {3'b000, all_sync}, {3'b000, &e.e_sync});
        chk("loss_cnt", i, loss_cnt, {e.e_l1, e.e_l0});
        if (e.e_echk != 2'b00)
          chk("rx_even", i, {2'b00, rx_even & e.e_echk}, {2'b00, e.e_even & e.e_echk});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
